// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port 256-word data memory.
// Latency: grant is combinational with req; response (rvalid/rdata/err) one cycle after grant.
// Backpressure: a requester simply holds req until it sees gnt; the loser is stalled, never dropped.
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration on conflict;
// leave it undefined for fixed priority (port 0 wins). Lock handling is the same in both.
//
// Ports (x = 0, 1):
//   clk, rst_n                      clock, asynchronous active-low reset
//   mx_req/we/addr/wdata/lock       request side of port x (port 0 = LSU, port 1 = loader/debug)
//   mx_gnt                          access accepted this cycle
//   mx_rvalid/rdata/err             registered response for the previous grant on port x
//   mem_we/mem_a/mem_wd, mem_rd     memory write enable, address, write data; async read data
module dmem_arbiter #(
   parameter int ADDR_DEPTH = 256,
   parameter int MAX_LOCK   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic        m0_lock,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic        m1_lock,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   // arbitration state
   logic        r_last;        // port granted most recently
   logic        r_owner_vld;   // a lock is held
   logic        r_owner;       // port holding the lock
   logic [3:0]  r_lock_cnt;    // consecutive grants under the current lock

   // response registers
   logic [1:0]  r_rvalid;
   logic [31:0] r_rdata0;
   logic [31:0] r_rdata1;
   logic        r_err0;
   logic        r_err1;

   logic [1:0]  w_req;
   logic        w_lock_active;
   logic        w_lock_expired;
   logic        w_sel;
   logic        w_any;
   logic        w_we;
   logic        w_lock;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic        w_in_range;
   logic [31:0] w_rd_dat;

   assign w_req = {m1_req, m0_req};

   // The owner keeps the port while it keeps requesting and is under its budget.
   assign w_lock_active  = r_owner_vld && w_req[r_owner] && (r_lock_cnt < 4'(MAX_LOCK));
   // Budget used up: the owner must yield to the other port if that one is waiting.
   assign w_lock_expired = r_owner_vld && w_req[r_owner] && !w_lock_active;

   always_comb begin
      w_sel = 1'b0;
      if (w_lock_active) begin
         w_sel = r_owner;
      end else if (w_req == 2'b11) begin
         if (w_lock_expired) begin
            w_sel = ~r_owner;
         end else begin
`ifdef DMEM_ARB_RR_EN
            w_sel = ~r_last;
`else
            // r_last is still tracked in this build; it just never changes the outcome
            w_sel = 1'b0 & r_last;
`endif
         end
      end else begin
         w_sel = w_req[1];
      end
   end

   // Gated by rst_n so grants and memory strobes drop the moment reset asserts.
   assign w_any  = rst_n & (|w_req);
   assign m0_gnt = w_any & ~w_sel;
   assign m1_gnt = w_any &  w_sel;

   assign w_we       = w_sel ? m1_we    : m0_we;
   assign w_lock     = w_sel ? m1_lock  : m0_lock;
   assign w_addr     = w_sel ? m1_addr  : m0_addr;
   assign w_wdata    = w_sel ? m1_wdata : m0_wdata;
   assign w_in_range = (w_addr < 32'(ADDR_DEPTH));

   assign mem_we = w_any & w_we & w_in_range;
   assign mem_a  = w_any ? w_addr  : 32'd0;
   assign mem_wd = w_any ? w_wdata : 32'd0;

   // Writes and out-of-range accesses return zero data.
   assign w_rd_dat = (!w_we && w_in_range) ? mem_rd : 32'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last      <= 1'b1;
         r_owner_vld <= 1'b0;
         r_owner     <= 1'b0;
         r_lock_cnt  <= 4'd0;
      end else if (w_any) begin
         r_last <= w_sel;
         if (w_lock) begin
            r_owner_vld <= 1'b1;
            r_owner     <= w_sel;
            // only an unexpired lock counts as the same owner continuing
            r_lock_cnt  <= w_lock_active ? (r_lock_cnt + 4'd1) : 4'd1;
         end else begin
            r_owner_vld <= 1'b0;
            r_lock_cnt  <= 4'd0;
         end
      end else if (r_owner_vld && !w_req[r_owner]) begin
         r_owner_vld <= 1'b0;
         r_lock_cnt  <= 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid <= 2'b00;
         r_rdata0 <= 32'd0;
         r_rdata1 <= 32'd0;
         r_err0   <= 1'b0;
         r_err1   <= 1'b0;
      end else begin
         r_rvalid <= {m1_gnt, m0_gnt};
         if (m0_gnt) begin
            r_rdata0 <= w_rd_dat;
            r_err0   <= ~w_in_range;
         end
         if (m1_gnt) begin
            r_rdata1 <= w_rd_dat;
            r_err1   <= ~w_in_range;
         end
      end
   end

   assign m0_rvalid = r_rvalid[0];
   assign m1_rvalid = r_rvalid[1];
   assign m0_rdata  = r_rdata0;
   assign m1_rdata  = r_rdata1;
   assign m0_err    = r_err0;
   assign m1_err    = r_err1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, per-port response scoreboard, directed scenarios.
// Latency: expects responses exactly one cycle after each expected grant.
// Backpressure: stalled requesters keep req asserted; no expectation is pushed for a lost cycle.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m0_lock;
   logic [31:0] m0_addr, m0_wdata;
   logic        m0_gnt, m0_rvalid, m0_err;
   logic [31:0] m0_rdata;
   logic        m1_req, m1_we, m1_lock;
   logic [31:0] m1_addr, m1_wdata;
   logic        m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m1_rdata;
   logic        mem_we;
   logic [31:0] mem_a, mem_wd, mem_rd;

   logic [31:0] mem [0:255];

   dmem_arbiter #(.ADDR_DEPTH(256), .MAX_LOCK(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // single-port memory: asynchronous read, write on the rising edge
   assign mem_rd = mem[mem_a[7:0]];
   always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          stamp;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t q0[$];
   rsp_t q1[$];
   rsp_t mon_e;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // response monitor: every rvalid must match the oldest expectation, one cycle after its grant
   always @(negedge clk) begin
      if (rst_n) begin
         if (q0.size() > 0 && q0[0].stamp < cyc - 1) begin
            chk("m0_rvalid_missing", 32'd0, 32'd1);
            mon_e = q0.pop_front();
         end
         if (m0_rvalid) begin
            if (q0.size() == 0) chk("m0_stale_rvalid", 32'd1, 32'd0);
            else begin
               mon_e = q0.pop_front();
               chk("m0_rsp_latency", 32'(cyc), 32'(mon_e.stamp + 1));
               chk("m0_rdata", m0_rdata, mon_e.rdata);
               chk("m0_err", {31'd0, m0_err}, {31'd0, mon_e.err});
            end
         end
         if (q1.size() > 0 && q1[0].stamp < cyc - 1) begin
            chk("m1_rvalid_missing", 32'd0, 32'd1);
            mon_e = q1.pop_front();
         end
         if (m1_rvalid) begin
            if (q1.size() == 0) chk("m1_stale_rvalid", 32'd1, 32'd0);
            else begin
               mon_e = q1.pop_front();
               chk("m1_rsp_latency", 32'(cyc), 32'(mon_e.stamp + 1));
               chk("m1_rdata", m1_rdata, mon_e.rdata);
               chk("m1_err", {31'd0, m1_err}, {31'd0, mon_e.err});
            end
         end
      end
   end

   task automatic idle_inputs();
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
   endtask

   // wait to mid-cycle, check grants, record expected responses for granted ports
   task automatic gnt_check(input logic g0, input logic g1,
                            input logic [31:0] rd0, input logic e0,
                            input logic [31:0] rd1, input logic e1);
      @(negedge clk); #1;
      chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, g0});
      chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, g1});
      if (g0) q0.push_back('{stamp: cyc, rdata: rd0, err: e0});
      if (g1) q1.push_back('{stamp: cyc, rdata: rd1, err: e1});
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic idle_cycle();
      idle_inputs();
      gnt_check(0, 0, 0, 0, 0, 0);
      chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
      chk("idle_mem_a", mem_a, 32'd0);
      chk("idle_mem_wd", mem_wd, 32'd0);
      next_cycle();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_flags"}, {25'd0, m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_we}, 32'd0);
      chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
      chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
      chk({tag, "_mem_a"}, mem_a, 32'd0);
      chk({tag, "_mem_wd"}, mem_wd, 32'd0);
   endtask

   int win;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
      mem[60] = 32'h0000_00AB;
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      next_cycle();

      // single read
      m0_req = 1; m0_addr = 60;
      gnt_check(1, 0, 32'h0000_00AB, 0, 0, 0);
      chk("rd_mem_a", mem_a, 32'd60);
      chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
      next_cycle();
      idle_cycle();

      // write then read-after-write on port 1
      m1_req = 1; m1_we = 1; m1_addr = 5; m1_wdata = 32'hDEAD_BEEF;
      gnt_check(0, 1, 0, 0, 32'd0, 0);
      chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
      chk("wr_mem_a", mem_a, 32'd5);
      chk("wr_mem_wd", mem_wd, 32'hDEAD_BEEF);
      next_cycle();
      m1_we = 0; m1_wdata = 0;
      gnt_check(0, 1, 0, 0, 32'hDEAD_BEEF, 0);
      next_cycle();
      idle_cycle();
      chk("m1_rdata_hold", m1_rdata, 32'hDEAD_BEEF);
      chk("m1_rvalid_low", {31'd0, m1_rvalid}, 32'd0);

      // conflict, no lock
      for (int k = 0; k < 4; k++) begin
         m0_req = 1; m0_addr = 100 + 32'(k);
         m1_req = 1; m1_addr = 200 + 32'(k);
`ifdef DMEM_ARB_RR_EN
         win = k % 2;
`else
         win = 0;
`endif
         gnt_check(win == 0, win == 1, 32'hA000_0000 + 100 + 32'(k), 0,
                   32'hA000_0000 + 200 + 32'(k), 0);
         next_cycle();
      end
      idle_cycle();

      // lock limit: port 1 locks alone, then keeps the lock against port 0
      m1_req = 1; m1_lock = 1; m1_addr = 10;
      gnt_check(0, 1, 0, 0, 32'hA000_000A, 0);
      next_cycle();
      m0_req = 1; m0_addr = 20;
      for (int i = 1; i < 8; i++) begin
         gnt_check(0, 1, 0, 0, 32'hA000_000A, 0);
         next_cycle();
      end
      gnt_check(1, 0, 32'hA000_0014, 0, 0, 0);
      next_cycle();
      idle_cycle();
      idle_cycle();

      // out-of-range write
      m0_req = 1; m0_we = 1; m0_addr = 300; m0_wdata = 32'h0000_1234;
      gnt_check(1, 0, 32'd0, 1, 0, 0);
      chk("oor_mem_we", {31'd0, mem_we}, 32'd0);
      next_cycle();
      idle_cycle();
      chk("oor_mem44", mem[44], 32'hA000_002C);
      chk("oor_err_hold", {31'd0, m0_err}, 32'd1);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);

      // reset in the middle of a locked burst with a response pending
      m1_req = 1; m1_lock = 1; m1_addr = 30;
      gnt_check(0, 1, 0, 0, 32'hA000_001E, 0);
      next_cycle();
      gnt_check(0, 1, 0, 0, 32'hA000_001E, 0);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      q0.delete();
      q1.delete();
      repeat (2) @(posedge clk);
      #1;
      m0_req = 1; m0_addr = 40; m1_req = 1; m1_lock = 0; m1_addr = 41;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_m0_gnt", {31'd0, m0_gnt}, 32'd1);
      chk("post_rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
      if (m0_gnt) q0.push_back('{stamp: cyc, rdata: 32'hA000_0028, err: 1'b0});
      next_cycle();
      idle_cycle();
      idle_cycle();
      chk("end_q0_drained", 32'(q0.size()), 32'd0);
      chk("end_q1_drained", 32'(q1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
